// File: rtl/text_fetch_ctrl.sv
// text_fetch_ctrl: fetches glyph rows for a 4-cell text strip and serializes them into a 1-bit text pixel
module text_fetch_ctrl #(
   parameter int X0 = 64,
   parameter int Y0 = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pixel_tick,
   input  logic        video_on,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   output logic [1:0]  selec,
   input  logic [6:0]  char_code,
   output logic [10:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic        text_on,
   output logic        text_pixel
);
   typedef enum logic [2:0] {IDLE, SEL, CODE, ROMW, LATCH} state_t;
   localparam logic [9:0] XT = 10'(X0 - 8);
   localparam logic [9:0] XW = 10'(X0);
   localparam logic [9:0] YT = 10'(Y0);
   state_t      state_q, state_d;
   logic [1:0]  selec_q, selec_d;
   logic [3:0]  row_q, row_d;
   logic [10:0] addr_q, addr_d;
   logic [7:0]  glyph_q, glyph_d, shreg_q, shreg_d;
   logic        on_q, on_d, pix_q, pix_d;
   logic [9:0]  dx_t, dx, dy;
   logic        in_y, in_x, trig, boundary;
   // Offsets wrap to large values left of / above the window, so one compare bounds each range.
   assign dx_t     = pixel_x - XT;
   assign dx       = pixel_x - XW;
   assign dy       = pixel_y - YT;
   assign in_y     = dy < 10'd16;
   assign in_x     = dx < 10'd32;
   assign boundary = dx[2:0] == 3'd0;
   assign trig     = pixel_tick && in_y && dx_t < 10'd32 && dx_t[2:0] == 3'd0;
   always_comb begin
      state_d = state_q;
      selec_d = selec_q;
      row_d   = row_q;
      addr_d  = addr_q;
      glyph_d = glyph_q;
      shreg_d = shreg_q;
      on_d    = on_q;
      pix_d   = pix_q;
      case (state_q)
         IDLE: if (trig) begin
            selec_d = dx_t[4:3];
            row_d   = dy[3:0];
            state_d = SEL;
         end
         SEL:  state_d = CODE;
         CODE: begin
            addr_d  = {char_code, row_q};
            state_d = ROMW;
         end
         ROMW: state_d = LATCH;
         LATCH: begin
            glyph_d = rom_data;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // The cell load reads glyph_q before a same-edge fetch could overwrite it.
      if (pixel_tick) begin
         on_d    = in_y && in_x && video_on;
         pix_d   = !on_d ? 1'b0 : boundary ? glyph_q[7] : shreg_q[7];
         shreg_d = !on_d ? shreg_q : boundary ? glyph_q << 1 : shreg_q << 1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         selec_q <= '0;
         row_q   <= '0;
         addr_q  <= '0;
         glyph_q <= '0;
         shreg_q <= '0;
         on_q    <= 1'b0;
         pix_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         selec_q <= selec_d;
         row_q   <= row_d;
         addr_q  <= addr_d;
         glyph_q <= glyph_d;
         shreg_q <= shreg_d;
         on_q    <= on_d;
         pix_q   <= pix_d;
      end
   end
   assign selec      = selec_q;
   assign rom_addr   = addr_q;
   assign text_on    = on_q;
   assign text_pixel = pix_q;
endmodule
